fv_edge_rd_arb: RTL and testbench

FV_EDGE_RD_ARB -- requirements
Module: fv_edge_rd_arb

---
 rtl/fv_edge_rd_arb.sv | 175 +++++++++++++++++
 tb/tb_fv_edge_rd_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fv_edge_rd_arb.sv
// Round-robin read arbiter between Edge PEs and one bank controller, with tagged response routing.
// Optional watchdog on WAIT_RSP enabled by defining FV_ARB_TIMEOUT_EN (adds timeout_err port).
module fv_edge_rd_arb #(
    parameter int unsigned NUM_PE    = 4,
    parameter int unsigned NODE_ID_W = 10,
    parameter int unsigned FV_W      = 256,
    parameter int unsigned TAG_W     = $clog2(NUM_PE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PE-1:0]             pe_req_valid,
    input  logic [NUM_PE*NODE_ID_W-1:0]   pe_req_node_id,
    output logic [NUM_PE-1:0]             pe_req_ready,
    input  logic                          bank_available,
    output logic                          req_valid,
    output logic [NODE_ID_W-1:0]          req_node_id,
    output logic [TAG_W-1:0]              req_pe_tag,
    input  logic                          rd_valid,
    input  logic                          rd_sos,
    input  logic                          rd_eos,
    input  logic [TAG_W-1:0]              rd_pe_tag,
    input  logic [FV_W-1:0]               rd_data,
    output logic [NUM_PE-1:0]             pe_rsp_valid,
    output logic                          pe_rsp_sos,
    output logic                          pe_rsp_eos,
    output logic [FV_W-1:0]               pe_rsp_data,
    output logic                          busy,
`ifdef FV_ARB_TIMEOUT_EN
    output logic                          timeout_err,
`endif
    output logic                          tag_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_t;

    state_t                 state_q, state_d;
    logic [TAG_W-1:0]       last_grant_q, last_grant_d;
    logic [TAG_W-1:0]       tag_d;
    logic [NODE_ID_W-1:0]   node_d;
    logic                   req_valid_d;
    logic [NUM_PE-1:0]      ready_d;
    logic [NUM_PE-1:0]      rsp_valid_d;
    logic                   sos_d, eos_d;
    logic [FV_W-1:0]        data_d;
    logic                   busy_d;
    logic                   tag_err_d;
    logic                   found;
    logic [TAG_W-1:0]       pick;
    logic [TAG_W-1:0]       cand;
    logic                   match;
`ifdef FV_ARB_TIMEOUT_EN
    logic [7:0]             wdog_q, wdog_d;
    logic                   timeout_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tag_d        = req_pe_tag;
        node_d       = req_node_id;
        req_valid_d  = 1'b0;
        ready_d      = '0;
        rsp_valid_d  = '0;
        sos_d        = 1'b0;
        eos_d        = 1'b0;
        data_d       = pe_rsp_data;
        tag_err_d    = tag_err;
        found        = 1'b0;
        pick         = '0;
        cand         = '0;
`ifdef FV_ARB_TIMEOUT_EN
        wdog_d       = wdog_q;
        timeout_d    = timeout_err;
`endif

        // Search starts just after the last winner; index wraps since NUM_PE is a power of two.
        for (int i = 0; i < NUM_PE; i++) begin
            cand = last_grant_q + TAG_W'(i + 1);
            if (!found && pe_req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        match = rd_valid && (state_q == StWaitRsp) && (rd_pe_tag == req_pe_tag);

        case (state_q)
            StIdle: begin
                if (bank_available && found) begin
                    tag_d         = pick;
                    node_d        = pe_req_node_id[int'(pick)*NODE_ID_W +: NODE_ID_W];
                    req_valid_d   = 1'b1;
                    ready_d[pick] = 1'b1;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitRsp;
`ifdef FV_ARB_TIMEOUT_EN
                wdog_d  = 8'd0;
`endif
            end
            StWaitRsp: begin
                if (match && rd_eos) begin
                    state_d      = StIdle;
                    last_grant_d = req_pe_tag;
                end
`ifdef FV_ARB_TIMEOUT_EN
                if (match) begin
                    wdog_d = 8'd0;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                    if (wdog_q == 8'd254) begin
                        state_d      = StIdle;
                        last_grant_d = req_pe_tag;
                        timeout_d    = 1'b1;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        if (rd_valid && !match) begin
            tag_err_d = 1'b1;
        end
        if (match) begin
            rsp_valid_d[rd_pe_tag] = 1'b1;
            sos_d                  = rd_sos;
            eos_d                  = rd_eos;
            data_d                 = rd_data;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= TAG_W'(NUM_PE - 1);
            req_valid    <= 1'b0;
            req_node_id  <= '0;
            req_pe_tag   <= '0;
            pe_req_ready <= '0;
            pe_rsp_valid <= '0;
            pe_rsp_sos   <= 1'b0;
            pe_rsp_eos   <= 1'b0;
            pe_rsp_data  <= '0;
            busy         <= 1'b0;
            tag_err      <= 1'b0;
`ifdef FV_ARB_TIMEOUT_EN
            wdog_q       <= 8'd0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_valid    <= req_valid_d;
            req_node_id  <= node_d;
            req_pe_tag   <= tag_d;
            pe_req_ready <= ready_d;
            pe_rsp_valid <= rsp_valid_d;
            pe_rsp_sos   <= sos_d;
            pe_rsp_eos   <= eos_d;
            pe_rsp_data  <= data_d;
            busy         <= busy_d;
            tag_err      <= tag_err_d;
`ifdef FV_ARB_TIMEOUT_EN
            wdog_q       <= wdog_d;
            timeout_err  <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_fv_edge_rd_arb.sv
// Directed bench for fv_edge_rd_arb: cycle table for grant/response basics, then hand sequences
// for round-robin streaming, async reset mid-stream and (with FV_ARB_TIMEOUT_EN) the watchdog.
module tb_fv_edge_rd_arb;

    localparam int NUM_PE = 4;
    localparam int NID_W  = 10;
    localparam int FV_W   = 256;
    localparam int TAG_W  = 2;

    logic                      clk;
    logic                      reset;
    logic [NUM_PE-1:0]         pe_req_valid;
    logic [NUM_PE*NID_W-1:0]   pe_req_node_id;
    logic [NUM_PE-1:0]         pe_req_ready;
    logic                      bank_available;
    logic                      req_valid;
    logic [NID_W-1:0]          req_node_id;
    logic [TAG_W-1:0]          req_pe_tag;
    logic                      rd_valid, rd_sos, rd_eos;
    logic [TAG_W-1:0]          rd_pe_tag;
    logic [FV_W-1:0]           rd_data;
    logic [NUM_PE-1:0]         pe_rsp_valid;
    logic                      pe_rsp_sos, pe_rsp_eos;
    logic [FV_W-1:0]           pe_rsp_data;
    logic                      busy, tag_err;
`ifdef FV_ARB_TIMEOUT_EN
    logic                      timeout_err;
`endif

    int errors = 0;
    int checks = 0;

    fv_edge_rd_arb #(
        .NUM_PE(NUM_PE), .NODE_ID_W(NID_W), .FV_W(FV_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset),
        .pe_req_valid(pe_req_valid), .pe_req_node_id(pe_req_node_id),
        .pe_req_ready(pe_req_ready), .bank_available(bank_available),
        .req_valid(req_valid), .req_node_id(req_node_id), .req_pe_tag(req_pe_tag),
        .rd_valid(rd_valid), .rd_sos(rd_sos), .rd_eos(rd_eos), .rd_pe_tag(rd_pe_tag),
        .rd_data(rd_data),
        .pe_rsp_valid(pe_rsp_valid), .pe_rsp_sos(pe_rsp_sos), .pe_rsp_eos(pe_rsp_eos),
        .pe_rsp_data(pe_rsp_data), .busy(busy),
`ifdef FV_ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic        bank;
        logic        rv;
        logic        sos;
        logic        eos;
        logic [1:0]  rtag;
        logic [15:0] rdat;
        logic        e_rv;
        logic [3:0]  e_rdy;
        logic [1:0]  e_tag;
        logic [3:0]  e_rsp;
        logic        e_sos;
        logic        e_eos;
        logic [15:0] e_dat;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rd();
        rd_valid = 1'b0; rd_sos = 1'b0; rd_eos = 1'b0; rd_pe_tag = '0; rd_data = '0;
    endtask

    task automatic wait_grant(input logic [1:0] exp_tag, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (req_valid) seen = 1'b1;
        end
        chk({name, "_seen"}, seen, 1'b1);
        chk({name, "_tag"}, req_pe_tag, exp_tag);
        chk({name, "_ready"}, pe_req_ready, 4'b0001 << exp_tag);
        chk({name, "_node"}, req_node_id, 10'h058 + exp_tag);
    endtask

    int beats[NUM_PE];
    int wait_cnt;

    initial begin
        pe_req_node_id = {10'h05B, 10'h05A, 10'h059, 10'h058};
        pe_req_valid   = '0;
        bank_available = 1'b1;
        idle_rd();
        reset = 1'b1;

        //        req     bank rv sos eos tag dat    | rv rdy     tag rsp     sos eos dat    busy err
        vecs[0] = '{4'b0100, 1, 0, 0, 0, 0, 16'h00,   1, 4'b0100, 2, 4'b0000, 0, 0, 16'h00, 1, 0};
        vecs[1] = '{4'b0000, 1, 0, 0, 0, 0, 16'h00,   0, 4'b0000, 2, 4'b0000, 0, 0, 16'h00, 1, 0};
        vecs[2] = '{4'b0000, 1, 1, 1, 0, 2, 16'h11,   0, 4'b0000, 2, 4'b0100, 1, 0, 16'h11, 1, 0};
        vecs[3] = '{4'b0000, 1, 0, 0, 0, 0, 16'h00,   0, 4'b0000, 2, 4'b0000, 0, 0, 16'h11, 1, 0};
        vecs[4] = '{4'b0000, 1, 1, 0, 1, 2, 16'h22,   0, 4'b0000, 2, 4'b0100, 0, 1, 16'h22, 0, 0};
        vecs[5] = '{4'b0001, 0, 0, 0, 0, 0, 16'h00,   0, 4'b0000, 2, 4'b0000, 0, 0, 16'h22, 0, 0};
        vecs[6] = '{4'b0010, 1, 0, 0, 0, 0, 16'h00,   1, 4'b0010, 1, 4'b0000, 0, 0, 16'h22, 1, 0};
        vecs[7] = '{4'b0000, 1, 0, 0, 0, 0, 16'h00,   0, 4'b0000, 1, 4'b0000, 0, 0, 16'h22, 1, 0};
        vecs[8] = '{4'b0000, 1, 1, 0, 0, 3, 16'h33,   0, 4'b0000, 1, 4'b0000, 0, 0, 16'h22, 1, 1};
        vecs[9] = '{4'b0000, 1, 1, 1, 1, 1, 16'h44,   0, 4'b0000, 1, 4'b0010, 1, 1, 16'h44, 0, 1};

        tick();
        tick();
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tag_err", tag_err, 1'b0);
        chk("rst_data", pe_rsp_data, '0);
        reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            pe_req_valid   = vecs[v].req;
            bank_available = vecs[v].bank;
            rd_valid       = vecs[v].rv;
            rd_sos         = vecs[v].sos;
            rd_eos         = vecs[v].eos;
            rd_pe_tag      = vecs[v].rtag;
            rd_data        = FV_W'(vecs[v].rdat);
            tick();
            chk($sformatf("v%0d_req_valid", v), req_valid, vecs[v].e_rv);
            chk($sformatf("v%0d_ready", v), pe_req_ready, vecs[v].e_rdy);
            chk($sformatf("v%0d_tag", v), req_pe_tag, vecs[v].e_tag);
            chk($sformatf("v%0d_node", v), req_node_id, 10'h058 + vecs[v].e_tag);
            chk($sformatf("v%0d_rsp_valid", v), pe_rsp_valid, vecs[v].e_rsp);
            chk($sformatf("v%0d_sos", v), pe_rsp_sos, vecs[v].e_sos);
            chk($sformatf("v%0d_eos", v), pe_rsp_eos, vecs[v].e_eos);
            chk($sformatf("v%0d_data", v), pe_rsp_data, FV_W'(vecs[v].e_dat));
            chk($sformatf("v%0d_busy", v), busy, vecs[v].e_busy);
            chk($sformatf("v%0d_tag_err", v), tag_err, vecs[v].e_err);
        end
        idle_rd();
        pe_req_valid = '0;

        // All PEs request continuously; five 4-beat streams.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < NUM_PE; p++) beats[p] = 0;
        pe_req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(2'(g % 4), $sformatf("rr%0d", g));
            tick();
            for (int b = 0; b < 4; b++) begin
                rd_valid  = 1'b1;
                rd_sos    = (b == 0);
                rd_eos    = (b == 3);
                rd_pe_tag = 2'(g % 4);
                rd_data   = FV_W'(32'hA000 + g * 16 + b);
                tick();
                for (int p = 0; p < NUM_PE; p++) if (pe_rsp_valid[p]) beats[p]++;
                chk($sformatf("rr%0d_b%0d_rsp", g, b), pe_rsp_valid, 4'b0001 << (g % 4));
                chk($sformatf("rr%0d_b%0d_sos", g, b), pe_rsp_sos, b == 0);
                chk($sformatf("rr%0d_b%0d_eos", g, b), pe_rsp_eos, b == 3);
                chk($sformatf("rr%0d_b%0d_data", g, b), pe_rsp_data, FV_W'(32'hA000 + g * 16 + b));
            end
            idle_rd();
            chk($sformatf("rr%0d_done_busy", g), busy, 1'b0);
        end
        chk("rr_beats_pe0", beats[0], 8);
        chk("rr_beats_pe1", beats[1], 4);
        chk("rr_beats_pe2", beats[2], 4);
        chk("rr_beats_pe3", beats[3], 4);
        chk("rr_tag_err", tag_err, 1'b0);

        // Async reset during beat 2 of the stream granted to PE1.
        wait_grant(2'd1, "mid");
        tick();
        rd_valid = 1'b1; rd_sos = 1'b1; rd_pe_tag = 2'd1; rd_data = FV_W'(32'h5151);
        tick();
        chk("mid_b1_rsp", pe_rsp_valid, 4'b0010);
        rd_sos = 1'b0; rd_data = FV_W'(32'h5252);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req_valid", req_valid, 1'b0);
        chk("arst_ready", pe_req_ready, 4'b0000);
        chk("arst_node", req_node_id, 10'h000);
        chk("arst_tag", req_pe_tag, 2'd0);
        chk("arst_rsp_valid", pe_rsp_valid, 4'b0000);
        chk("arst_sos", pe_rsp_sos, 1'b0);
        chk("arst_eos", pe_rsp_eos, 1'b0);
        chk("arst_data", pe_rsp_data, '0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_tag_err", tag_err, 1'b0);
        tick();
        reset = 1'b0;
        idle_rd();
        wait_grant(2'd0, "post_rst");
        pe_req_valid = '0;

`ifdef FV_ARB_TIMEOUT_EN
        begin
            logic fired;
            fired    = 1'b0;
            wait_cnt = 0;
            for (int i = 0; i < 400 && !fired; i++) begin
                tick();
                if (timeout_err) fired = 1'b1;
                else if (busy) wait_cnt++;
            end
            chk("to_fired", fired, 1'b1);
            chk("to_wait_cycles", wait_cnt, 255);
            chk("to_busy", busy, 1'b0);
            pe_req_valid = 4'b1111;
            wait_grant(2'd1, "to_next");
            pe_req_valid = '0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
